iddr141a_word_align: RTL and testbench

Word-alignment controller for the 1:14 DDR deserializer (7:1 LVDS video/camera links). Sits directly downstream of the deserializer on the SCLK domain: consumes its 14-bit parallel word, compares it against a known training pattern, and pulses ALIGNWD back into the deserializer until the word boundary is correct. Reports lock, lock loss and alignment failure to link-management logic.

---
 rtl/iddr141a_word_align.sv | 183 ++++++++++++++++++
 tb/tb_iddr141a_word_align.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iddr141a_word_align.sv
// Word-alignment controller for the 1:14 DDR deserializer: pulses ALIGNWD until DIN equals the training word.
// Optional build macro ALIGN_MASK_EN adds a MASK input for don't-care bits in the compare.
module iddr141a_word_align #(
  parameter logic [13:0] PATTERN    = 14'h31E3,
  parameter int unsigned MATCH_CNT  = 16,
  parameter int unsigned LOSS_CNT   = 4,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned MAX_SLIP   = 14
) (
  input  logic        SCLK,
  input  logic        RST,
  input  logic [13:0] DIN,
`ifdef ALIGN_MASK_EN
  input  logic [13:0] MASK,
`endif
  input  logic        START,
  output logic        ALIGNWD,
  output logic        LOCK,
  output logic        FAIL,
  output logic        BUSY,
  output logic [3:0]  SLIP_CNT
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAILED = 3'd5
  } state_t;

  localparam logic [7:0] MATCH_C       = 8'(MATCH_CNT);
  localparam logic [7:0] LOSS_C        = 8'(LOSS_CNT);
  localparam logic [3:0] SETTLE_LAST_C = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] MAX_SLIP_C    = 4'(MAX_SLIP);

  state_t      state_r;
  logic        alignwd_r;
  logic        lock_r;
  logic        fail_r;
  logic        busy_r;
  logic [3:0]  slip_cnt_r;
  logic [7:0]  match_cnt_r;
  logic [7:0]  miss_cnt_r;
  logic [3:0]  settle_cnt_r;
  logic [13:0] diff_s;
  logic        match_s;
  logic [7:0]  match_inc_s;
  logic [7:0]  miss_inc_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Word compare; an X/Z bit leaves match_s unknown, which the state machine treats as a mismatch.
  always_comb begin
`ifdef ALIGN_MASK_EN
    diff_s = (DIN ^ PATTERN) & MASK;
`else
    diff_s = DIN ^ PATTERN;
`endif
    match_s     = (diff_s == 14'd0);
    match_inc_s = sat_inc8(match_cnt_r);
    miss_inc_s  = sat_inc8(miss_cnt_r);
  end

  // Alignment state machine with registered status outputs.
  always_ff @(posedge SCLK) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      alignwd_r    <= 1'b0;
      lock_r       <= 1'b0;
      fail_r       <= 1'b0;
      busy_r       <= 1'b0;
      slip_cnt_r   <= 4'd0;
      match_cnt_r  <= 8'd0;
      miss_cnt_r   <= 8'd0;
      settle_cnt_r <= 4'd0;
    end else if (START) begin
      state_r      <= ST_CHECK;
      alignwd_r    <= 1'b0;
      lock_r       <= 1'b0;
      fail_r       <= 1'b0;
      busy_r       <= 1'b1;
      slip_cnt_r   <= 4'd0;
      match_cnt_r  <= 8'd0;
      miss_cnt_r   <= 8'd0;
      settle_cnt_r <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          alignwd_r <= 1'b0;
          busy_r    <= 1'b0;
        end
        ST_CHECK: begin
          alignwd_r  <= 1'b0;
          miss_cnt_r <= 8'd0;
          if (match_s) begin
            match_cnt_r <= match_inc_s;
            if (match_inc_s == MATCH_C) begin
              state_r <= ST_LOCKED;
              lock_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_CHECK;
            end
          end else begin
            match_cnt_r <= 8'd0;
            if (slip_cnt_r < MAX_SLIP_C) begin
              // The pulse is registered on entry so it occupies exactly the SLIP cycle.
              state_r    <= ST_SLIP;
              alignwd_r  <= 1'b1;
              slip_cnt_r <= sat_inc4(slip_cnt_r);
            end else begin
              state_r <= ST_FAILED;
              fail_r  <= 1'b1;
              busy_r  <= 1'b0;
            end
          end
        end
        ST_SLIP: begin
          state_r      <= ST_SETTLE;
          alignwd_r    <= 1'b0;
          settle_cnt_r <= 4'd0;
        end
        ST_SETTLE: begin
          alignwd_r <= 1'b0;
          if (settle_cnt_r >= SETTLE_LAST_C) begin
            state_r      <= ST_CHECK;
            match_cnt_r  <= 8'd0;
            settle_cnt_r <= 4'd0;
          end else begin
            settle_cnt_r <= sat_inc4(settle_cnt_r);
          end
        end
        ST_LOCKED: begin
          alignwd_r <= 1'b0;
          if (match_s) begin
            miss_cnt_r <= 8'd0;
          end else if (miss_inc_s == LOSS_C) begin
            // Lock lost: restart the search from a clean slip budget.
            state_r     <= ST_CHECK;
            lock_r      <= 1'b0;
            busy_r      <= 1'b1;
            slip_cnt_r  <= 4'd0;
            match_cnt_r <= 8'd0;
            miss_cnt_r  <= 8'd0;
          end else begin
            miss_cnt_r <= miss_inc_s;
          end
        end
        ST_FAILED: begin
          alignwd_r <= 1'b0;
          fail_r    <= 1'b1;
          busy_r    <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          alignwd_r    <= 1'b0;
          lock_r       <= 1'b0;
          fail_r       <= 1'b0;
          busy_r       <= 1'b0;
          slip_cnt_r   <= 4'd0;
          match_cnt_r  <= 8'd0;
          miss_cnt_r   <= 8'd0;
          settle_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  assign ALIGNWD  = alignwd_r;
  assign LOCK     = lock_r;
  assign FAIL     = fail_r;
  assign BUSY     = busy_r;
  assign SLIP_CNT = slip_cnt_r;

endmodule

// File: tb/tb_iddr141a_word_align.sv
// Self-checking bench for iddr141a_word_align; a deserializer model rotates DIN back one bit per ALIGNWD.
// Expected timing is computed from the slip/settle/match arithmetic, not from the state machine.
module tb_iddr141a_word_align;

  localparam logic [13:0] PAT      = 14'h31E3;
  localparam int          MATCH_N  = 16;
  localparam int          LOSS_N   = 4;
  localparam int          SETTLE_N = 4;
  localparam int          SLIP_MAX = 14;
  localparam int          SPACING  = 1 + SETTLE_N + 1;

  logic        SCLK = 1'b0;
  logic        RST;
  logic        START;
  logic [13:0] DIN;
`ifdef ALIGN_MASK_EN
  logic [13:0] MASK;
`endif
  logic        ALIGNWD;
  logic        LOCK;
  logic        FAIL;
  logic        BUSY;
  logic [3:0]  SLIP_CNT;

  int total = 0;
  int bad   = 0;
  int pulses[$];
  int lock_at;
  int fail_at;
  int off;

  iddr141a_word_align dut (
    .SCLK     (SCLK),
    .RST      (RST),
    .DIN      (DIN),
`ifdef ALIGN_MASK_EN
    .MASK     (MASK),
`endif
    .START    (START),
    .ALIGNWD  (ALIGNWD),
    .LOCK     (LOCK),
    .FAIL     (FAIL),
    .BUSY     (BUSY),
    .SLIP_CNT (SLIP_CNT)
  );

  always #5 SCLK = ~SCLK;

  function automatic logic [13:0] rotl(input logic [13:0] v, input int n);
    logic [13:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[12:0], r[13]};
    return r;
  endfunction

  function automatic logic [13:0] bad_word();
    logic [13:0] w;
    w = 14'($urandom);
    if (w == PAT) w = w ^ 14'h0001;
    return w;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge SCLK);
    #2;
  endtask

  task automatic do_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // mode 0: rotated pattern tracking ALIGNWD, 1: never-matching words, 2: random upper half
  task automatic run(input int ncyc, input int mode);
    pulses.delete();
    lock_at = -1;
    fail_at = -1;
    for (int c = 1; c <= ncyc; c++) begin
      if (mode == 0) DIN = rotl(PAT, off);
      else if (mode == 1) DIN = bad_word();
      else DIN = {7'($urandom), PAT[6:0]};
      tick();
      if (ALIGNWD === 1'b1) begin
        pulses.push_back(c);
        if (off > 0) off--;
      end
      if (LOCK === 1'b1 && lock_at < 0) lock_at = c;
      if (FAIL === 1'b1 && fail_at < 0) fail_at = c;
    end
  endtask

  task automatic chk_spacing(input string tag, input int n);
    for (int i = 0; i < n && i < pulses.size(); i++)
      chk(tag, pulses[i], 1 + SPACING * i);
  endtask

  initial begin
    int r;
    int miss_run;
    logic want_bad;
    RST   = 1'b1;
    START = 1'b0;
    DIN   = 14'd0;
    off   = 0;
`ifdef ALIGN_MASK_EN
    MASK  = 14'h3FFF;
`endif
    tick(); tick(); tick();
    chk("rst_alignwd", int'(ALIGNWD), 0);
    chk("rst_lock", int'(LOCK), 0);
    chk("rst_fail", int'(FAIL), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_slip", int'(SLIP_CNT), 0);
    RST = 1'b0;

    // Already aligned: lock after MATCH_N samples, no slips.
    off = 0;
    DIN = PAT;
    do_start();
    chk("start_busy", int'(BUSY), 1);
    run(MATCH_N + 4, 0);
    chk("aligned_lock_at", lock_at, MATCH_N);
    chk("aligned_pulses", pulses.size(), 0);
    chk("aligned_slip", int'(SLIP_CNT), 0);
    chk("aligned_busy", int'(BUSY), 0);

    // Rotated input: one slip per bit of rotation, then lock.
    for (int rep = 0; rep < 3; rep++) begin
      r = (rep == 0) ? 3 : int'($urandom_range(1, 6));
      off = r;
      do_start();
      run(SPACING * r + MATCH_N + 8, 0);
      chk("rot_pulses", pulses.size(), r);
      chk_spacing("rot_spacing", r);
      chk("rot_slip", int'(SLIP_CNT), r);
      chk("rot_lock_at", lock_at, SPACING * r + MATCH_N);
    end

    // Locked: short error bursts are tolerated.
    for (int k = 0; k < LOSS_N - 1; k++) begin
      DIN = bad_word();
      tick();
      chk("burst3_lock", int'(LOCK), 1);
    end
    DIN = PAT;
    tick();
    chk("burst3_recover", int'(LOCK), 1);
    miss_run = 0;
    for (int k = 0; k < 30; k++) begin
      want_bad = ($urandom_range(0, 1) == 1) && (miss_run < LOSS_N - 1);
      miss_run = want_bad ? miss_run + 1 : 0;
      DIN = want_bad ? bad_word() : PAT;
      tick();
      chk("rand_burst_lock", int'(LOCK), 1);
    end
    DIN = PAT;
    tick();
    for (int k = 1; k <= LOSS_N; k++) begin
      DIN = bad_word();
      tick();
      chk("loss_lock", int'(LOCK), (k < LOSS_N) ? 1 : 0);
    end
    chk("loss_slip", int'(SLIP_CNT), 0);
    chk("loss_busy", int'(BUSY), 1);
    chk("loss_alignwd", int'(ALIGNWD), 0);

    // Never matches: MAX slips then FAIL.
    do_start();
    run(SPACING * SLIP_MAX + 15, 1);
    chk("fail_pulses", pulses.size(), SLIP_MAX);
    chk_spacing("fail_spacing", SLIP_MAX);
    chk("fail_at", fail_at, SPACING * SLIP_MAX + 1);
    chk("fail_flag", int'(FAIL), 1);
    chk("fail_busy", int'(BUSY), 0);
    chk("fail_lock", int'(LOCK), 0);
    chk("fail_slip", int'(SLIP_CNT), SLIP_MAX);
    DIN = PAT;
    do_start();
    chk("restart_fail", int'(FAIL), 0);
    chk("restart_busy", int'(BUSY), 1);
    chk("restart_slip", int'(SLIP_CNT), 0);

    // START during SETTLE.
    DIN = bad_word();
    do_start();
    tick();
    chk("settle_pre_pulse", int'(ALIGNWD), 1);
    tick();
    r = int'($urandom_range(0, 3));
    for (int k = 0; k < r; k++) tick();
    chk("settle_pre_alignwd", int'(ALIGNWD), 0);
    chk("settle_pre_busy", int'(BUSY), 1);
    DIN = PAT;
    do_start();
    chk("settle_start_alignwd", int'(ALIGNWD), 0);
    chk("settle_start_slip", int'(SLIP_CNT), 0);
    chk("settle_start_busy", int'(BUSY), 1);
    off = 0;
    run(MATCH_N + 4, 0);
    chk("settle_relock_at", lock_at, MATCH_N);
    chk("settle_relock_pulses", pulses.size(), 0);

    // RST during SLIP truncates the pulse and returns to IDLE.
    DIN = bad_word();
    do_start();
    tick();
    chk("rstslip_pulse", int'(ALIGNWD), 1);
    chk("rstslip_slip1", int'(SLIP_CNT), 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rstslip_alignwd", int'(ALIGNWD), 0);
    chk("rstslip_busy", int'(BUSY), 0);
    chk("rstslip_slip", int'(SLIP_CNT), 0);
    chk("rstslip_lock", int'(LOCK), 0);
    run(8, 1);
    chk("rstslip_idle_pulses", pulses.size(), 0);
    chk("rstslip_idle_busy", int'(BUSY), 0);

`ifdef ALIGN_MASK_EN
    // Only the low seven bits are compared.
    MASK = 14'h007F;
    do_start();
    run(MATCH_N + 4, 2);
    chk("mask_lock_at", lock_at, MATCH_N);
    chk("mask_pulses", pulses.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
